// File: rtl/axis_snooper.sv
// Passive AXI-Stream tap: claims the p3 buffer on offer, writes each captured
// packet into it word by word, raises sn_done at packet end and counts drops.
module axis_snooper #(
  parameter int SN_FWD_ADDR_WIDTH = 9,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int INC_WIDTH         = 8,
  parameter int DROP_CNT_WIDTH    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SN_FWD_DATA_WIDTH-1:0]   sn_TDATA,
  input  logic [SN_FWD_DATA_WIDTH/8-1:0] sn_TKEEP,
  input  logic                           sn_TVALID,
  input  logic                           sn_TREADY,
  input  logic                           sn_TLAST,
  output logic [SN_FWD_ADDR_WIDTH-1:0]   sn_addr,
  output logic [SN_FWD_DATA_WIDTH-1:0]   sn_wr_data,
  output logic                           sn_wr_en,
  output logic [INC_WIDTH-1:0]           sn_byte_inc,
  output logic                           sn_done,
  input  logic                           sn_done_ack,
  input  logic                           rdy_for_sn,
  output logic                           rdy_for_sn_ack,
  output logic [DROP_CNT_WIDTH-1:0]      drop_cnt,
  output logic                           truncated
);

  localparam int AW  = SN_FWD_ADDR_WIDTH;
  localparam int DW  = SN_FWD_DATA_WIDTH;
  localparam int KW  = SN_FWD_DATA_WIDTH / 8;
  localparam int DCW = DROP_CNT_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPT,
    S_FIN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 in_pkt_q, in_pkt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wr_data_q, wr_data_d;
  logic                 wr_en_q, wr_en_d;
  logic [INC_WIDTH-1:0] byte_inc_q, byte_inc_d;
  logic                 full_q, full_d;
  logic                 disc_q, disc_d;
  logic                 trunc_q, trunc_d;
  logic [DCW-1:0]       drop_q, drop_d;

  logic                 beat;
  logic                 drop_pkt;
  logic [AW-1:0]        wr_addr;
  logic [INC_WIDTH-1:0] keep_cnt;

  assign beat = sn_TVALID & sn_TREADY;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KW; i++) begin
      keep_cnt = keep_cnt + INC_WIDTH'(sn_TKEEP[i]);
    end
  end

  // A packet whose first beat lands outside ARMED has no buffer to go to.
  assign drop_pkt = beat & ~in_pkt_q & (state_q inside {S_IDLE, S_FIN, S_DONE});

  // NOTE: every variable gets its default before the case statement, so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    in_pkt_d       = in_pkt_q;
    addr_d         = addr_q;
    wr_data_d      = wr_data_q;
    wr_en_d        = 1'b0;
    byte_inc_d     = byte_inc_q;
    full_d         = full_q;
    disc_d         = disc_q;
    trunc_d        = trunc_q;
    drop_d         = drop_q;
    rdy_for_sn_ack = 1'b0;
    wr_addr        = (state_q == S_ARMED) ? '0 : addr_q + AW'(1);

    if (beat) begin
      in_pkt_d = ~sn_TLAST;
    end

    if (drop_pkt && !(&drop_q)) begin
      drop_d = drop_q + DCW'(1);
    end

    case (state_q)
      S_IDLE: begin
        // Claim only between packets so the buffer always starts on a first beat.
        if (rdy_for_sn && !in_pkt_q && !beat) begin
          rdy_for_sn_ack = rst;
          state_d        = S_ARMED;
          addr_d         = '0;
          full_d         = 1'b0;
          disc_d         = 1'b0;
          trunc_d        = 1'b0;
        end
      end
      S_ARMED, S_CAPT: begin
        if (beat) begin
          if (full_q) begin
            disc_d = 1'b1;
          end else begin
            wr_en_d    = 1'b1;
            addr_d     = wr_addr;
            wr_data_d  = sn_TDATA;
            byte_inc_d = keep_cnt;
            full_d     = &wr_addr;
          end
          if (sn_TLAST) begin
            state_d = S_FIN;
            trunc_d = disc_q | full_q;
          end else begin
            state_d = S_CAPT;
          end
        end
      end
      S_FIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (sn_done_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      in_pkt_q   <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      byte_inc_q <= '0;
      full_q     <= 1'b0;
      disc_q     <= 1'b0;
      trunc_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_pkt_q   <= in_pkt_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      byte_inc_q <= byte_inc_d;
      full_q     <= full_d;
      disc_q     <= disc_d;
      trunc_q    <= trunc_d;
      drop_q     <= drop_d;
    end
  end

  assign sn_addr     = addr_q;
  assign sn_wr_data  = wr_data_q;
  assign sn_wr_en    = wr_en_q;
  assign sn_byte_inc = byte_inc_q;
  assign sn_done     = (state_q == S_DONE);
  assign drop_cnt    = drop_q;
  assign truncated   = trunc_q;

endmodule
